// File: rtl/tick_sched.sv
// tick_sched: shared-prescaler multi-channel tick scheduler with round-robin event delivery
module tick_sched #(
  parameter int F0 = 50_000_000,
  parameter int F1 = 1_000,
  parameter int N_CH = 4,
  parameter int PW = 16,
  localparam int CHW = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_valid,
  input  logic [CHW-1:0]  cfg_ch,
  input  logic [1:0]      cfg_op,
  input  logic [PW-1:0]   cfg_period,
  output logic            base_tick,
  output logic            evt_valid,
  output logic [CHW-1:0]  evt_ch,
  input  logic            evt_ready,
  output logic [N_CH-1:0] busy,
  output logic [N_CH-1:0] overrun
);
  localparam int PRESC = F0 / F1;
  localparam int CNTW = $clog2(PRESC);
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [N_CH-1:0] run_q, run_d, periodic_q, periodic_d, pend_q, pend_d, overrun_q, overrun_d;
  logic [N_CH-1:0][PW-1:0] rem_q, rem_d, period_q, period_d;
  logic [CHW-1:0] ptr_q, ptr_d, evt_ch_q, evt_ch_d, sel, cand;
  logic evt_valid_q, evt_valid_d, load, hit;
  assign base_tick = (cnt_q == CNTW'(PRESC - 1));
  assign evt_valid = evt_valid_q;
  assign evt_ch = evt_ch_q;
  assign busy = run_q;
  assign overrun = overrun_q;
  always_comb begin
    cnt_d = base_tick ? '0 : cnt_q + CNTW'(1);
    sel = ptr_q;
    cand = ptr_q;
    for (int k = N_CH - 1; k >= 0; k--) begin
      cand = (int'(ptr_q) + k >= N_CH) ? CHW'(int'(ptr_q) + k - N_CH) : CHW'(int'(ptr_q) + k);
      if (pend_q[cand]) sel = cand;
    end
    load = (!evt_valid_q || evt_ready) && |pend_q;
    evt_valid_d = load || (evt_valid_q && !evt_ready);
    evt_ch_d = load ? sel : evt_ch_q;
    ptr_d = load ? ((sel == CHW'(N_CH - 1)) ? '0 : sel + CHW'(1)) : ptr_q;
    run_d = run_q;
    periodic_d = periodic_q;
    rem_d = rem_q;
    period_d = period_q;
    overrun_d = overrun_q;
    pend_d = pend_q;
    hit = 1'b0;
    if (load) pend_d[sel] = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      hit = cfg_valid && (cfg_ch == CHW'(i));
      if (hit && cfg_op == 2'b00) begin
        run_d[i] = 1'b0;
        rem_d[i] = '0;
        pend_d[i] = 1'b0;
      end else if (hit && cfg_op != 2'b11 && cfg_period != '0) begin
        run_d[i] = 1'b1;
        periodic_d[i] = cfg_op[1];
        rem_d[i] = cfg_period;
        period_d[i] = cfg_period;
        overrun_d[i] = 1'b0;
      end else if (base_tick && run_q[i]) begin
        if (rem_q[i] == PW'(1)) begin
          pend_d[i] = 1'b1;
          if (pend_q[i] && !(load && sel == CHW'(i))) overrun_d[i] = 1'b1;
          run_d[i] = periodic_q[i];
          rem_d[i] = periodic_q[i] ? period_q[i] : '0;
        end else begin
          rem_d[i] = rem_q[i] - PW'(1);
        end
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      run_q <= '0;
      periodic_q <= '0;
      pend_q <= '0;
      overrun_q <= '0;
      rem_q <= '0;
      period_q <= '0;
      ptr_q <= '0;
      evt_ch_q <= '0;
      evt_valid_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
      periodic_q <= periodic_d;
      pend_q <= pend_d;
      overrun_q <= overrun_d;
      rem_q <= rem_d;
      period_q <= period_d;
      ptr_q <= ptr_d;
      evt_ch_q <= evt_ch_d;
      evt_valid_q <= evt_valid_d;
    end
  end
endmodule

// File: tb/tb_tick_sched.sv
// tb_tick_sched: directed and random stimulus against a behavioural scheduler model
module tb_tick_sched;
  localparam int PRESC = 4;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_valid = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic [1:0] cfg_op = 2'b11;
  logic [15:0] cfg_period = '0;
  logic evt_ready = 1'b0;
  logic base_tick, evt_valid;
  logic [1:0] evt_ch;
  logic [3:0] busy, overrun;
  int errors = 0;
  int checks = 0;
  int m_cyc, m_ptr, m_ech;
  bit m_ev;
  bit m_run[N], m_periodic[N], m_pend[N], m_ovr[N];
  int m_rem[N], m_per[N];
  logic last_bt;
  int first;
  tick_sched #(.F0(8), .F1(2), .N_CH(4), .PW(16)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ch(cfg_ch), .cfg_op(cfg_op),
    .cfg_period(cfg_period), .base_tick(base_tick), .evt_valid(evt_valid), .evt_ch(evt_ch),
    .evt_ready(evt_ready), .busy(busy), .overrun(overrun)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h (model cycle %0d)", tag, got, exp, m_cyc);
    end
  endtask
  task automatic mreset();
    m_cyc = 0;
    m_ptr = 0;
    m_ech = 0;
    m_ev = 0;
    for (int c = 0; c < N; c++) begin
      m_run[c] = 0;
      m_periodic[c] = 0;
      m_pend[c] = 0;
      m_ovr[c] = 0;
      m_rem[c] = 0;
      m_per[c] = 0;
    end
  endtask
  function automatic logic [3:0] vec(input bit a[N]);
    logic [3:0] v;
    for (int c = 0; c < N; c++) v[c] = a[c];
    return v;
  endfunction
  task automatic model_step();
    bit tick, load, hit;
    bit old_pend[N];
    int s;
    tick = (m_cyc % PRESC) == PRESC - 1;
    old_pend = m_pend;
    s = -1;
    for (int j = 0; j < N; j++) if (s < 0 && m_pend[(m_ptr + j) % N]) s = (m_ptr + j) % N;
    load = (!m_ev || evt_ready) && s >= 0;
    if (load) begin
      m_pend[s] = 0;
      m_ev = 1;
      m_ech = s;
      m_ptr = (s + 1) % N;
    end else if (evt_ready) begin
      m_ev = 0;
    end
    for (int c = 0; c < N; c++) begin
      hit = cfg_valid && int'(cfg_ch) == c;
      if (hit && cfg_op == 2'd0) begin
        m_run[c] = 0;
        m_rem[c] = 0;
        m_pend[c] = 0;
      end else if (hit && (cfg_op == 2'd1 || cfg_op == 2'd2) && cfg_period != 0) begin
        m_per[c] = int'(cfg_period);
        m_rem[c] = int'(cfg_period);
        m_periodic[c] = (cfg_op == 2'd2);
        m_run[c] = 1;
        m_ovr[c] = 0;
      end else if (tick && m_run[c]) begin
        m_rem[c]--;
        if (m_rem[c] == 0) begin
          if (old_pend[c] && !(load && s == c)) m_ovr[c] = 1;
          m_pend[c] = 1;
          if (m_periodic[c]) m_rem[c] = m_per[c];
          else m_run[c] = 0;
        end
      end
    end
    m_cyc++;
  endtask
  task automatic cyc();
    @(negedge clk);
    last_bt = base_tick;
    chk("base_tick", {31'd0, base_tick}, {31'd0, (m_cyc % PRESC) == PRESC - 1});
    chk("evt_valid", {31'd0, evt_valid}, {31'd0, m_ev});
    if (m_ev) chk("evt_ch", {30'd0, evt_ch}, m_ech);
    chk("busy", {28'd0, busy}, {28'd0, vec(m_run)});
    chk("overrun", {28'd0, overrun}, {28'd0, vec(m_ovr)});
    model_step();
    @(posedge clk);
    #1;
  endtask
  task automatic cfg(input int ch, input int op, input int p);
    cfg_valid = 1'b1;
    cfg_ch = 2'(ch);
    cfg_op = 2'(op);
    cfg_period = 16'(p);
    cyc();
    cfg_valid = 1'b0;
    cfg_op = 2'b11;
  endtask
  initial begin
    mreset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_base_tick", {31'd0, base_tick}, 0);
    chk("rst_evt_valid", {31'd0, evt_valid}, 0);
    chk("rst_busy", {28'd0, busy}, 0);
    chk("rst_overrun", {28'd0, overrun}, 0);
    rst_n = 1'b1;
    evt_ready = 1'b1;
    repeat (16) cyc();
    cfg(0, 1, 3);
    repeat (20) cyc();
    cfg(1, 2, 2);
    cfg(2, 2, 2);
    repeat (28) cyc();
    cfg(1, 0, 0);
    cfg(2, 0, 0);
    evt_ready = 1'b0;
    repeat (4) cyc();
    cfg(3, 2, 1);
    repeat (16) cyc();
    evt_ready = 1'b1;
    repeat (8) cyc();
    cfg(3, 2, 1);
    cfg(3, 0, 0);
    repeat (6) cyc();
    for (int c = 0; c < N; c++) cfg(c, 2, 1);
    repeat (10) cyc();
    for (int n = 0; n < 20 && !m_pend[2]; n++) cyc();
    chk("pend2_seen", {31'd0, m_pend[2]}, 1);
    cfg(2, 0, 0);
    repeat (10) cyc();
    for (int c = 0; c < N; c++) cfg(c, 0, 0);
    repeat (6) cyc();
    for (int n = 0; n < 300; n++) begin
      cfg_valid = $urandom_range(0, 9) < 3;
      cfg_ch = 2'($urandom_range(0, 3));
      cfg_op = 2'($urandom_range(0, 3));
      cfg_period = 16'($urandom_range(0, 5));
      evt_ready = $urandom_range(0, 3) != 0;
      cyc();
    end
    cfg_valid = 1'b0;
    evt_ready = 1'b0;
    for (int c = 0; c < N; c++) cfg(c, 2, 1);
    for (int n = 0; n < 20 && !m_ev; n++) cyc();
    #2;
    chk("pre_rst_valid", {31'd0, evt_valid}, 1);
    chk("pre_rst_busy", {28'd0, busy}, 4'hf);
    rst_n = 1'b0;
    #1;
    chk("arst_base_tick", {31'd0, base_tick}, 0);
    chk("arst_evt_valid", {31'd0, evt_valid}, 0);
    chk("arst_busy", {28'd0, busy}, 0);
    chk("arst_overrun", {28'd0, overrun}, 0);
    mreset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    first = -1;
    for (int n = 0; n < 12; n++) begin
      cyc();
      if (last_bt && first < 0) first = n;
    end
    chk("first_tick_cycle", first, 3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tick_sched.md
Name: tick_sched

Overview:
Multi-channel tick scheduler built around a shared free-running prescaler, which emits a one-cycle base tick every F0/F1 clocks. Up to N_CH software-programmed channels count base ticks and expire in one-shot or periodic mode. Expiries are queued, one pending bit per channel, and delivered round-robin on a valid/ready event port. It sits between the CPU-side configuration logic and consumers that need timed events, such as LED blinkers, UART timeouts and sample strobes.

Parameters:
F0, 50_000_000, input clock frequency in Hz.
F1, 1_000, base tick frequency in Hz. PRESC = F0/F1 must be >= 2.
N_CH, 4, number of channels. Must be >= 2. CHW = $clog2(N_CH).
PW, 16, period register width, in base ticks.

Ports:
clk  in  1  clock.
rst_n  in  1  reset; asynchronous, active-low.
cfg_valid  in  1  config command strobe, accepted every cycle it is high.
cfg_ch  in  CHW  target channel. Values >= N_CH are ignored.
cfg_op  in  2  00 stop, 01 start one-shot, 10 start periodic, 11 no-op.
cfg_period  in  PW  period in base ticks, sampled on start.
base_tick  out  1  prescaler pulse.
evt_valid  out  1  event available.
evt_ch  out  CHW  channel that expired.
evt_ready  in  1  consumer accepts the event.
busy  out  N_CH  channel running.
overrun  out  N_CH  sticky: an expiry was lost.

Behaviour:
- Reset (async): prescaler count = 0 and all outputs = 0; every channel is IDLE with rem = 0, pend = 0, period = 0; round-robin pointer = 0.
- Prescaler:
  - Counts 0..PRESC-1 and wraps. It free-runs from reset release and is never gated by configuration.
  - base_tick = (count == PRESC-1). The first pulse occurs in cycle PRESC-1, where cycle 0 is the first cycle after reset release.
- Channel state: IDLE or RUN. Registers per channel: rem, period, mode, pend.
- Start (op 01/10):
  - If cfg_period == 0, the command is ignored entirely.
  - Otherwise the channel loads period = rem = cfg_period, latches mode, enters RUN, and clears overrun[ch].
  - pend is not changed. A restart while running reloads rem.
- Stop (op 00): channel goes to IDLE, rem = 0, pend = 0. overrun is kept. An event already held on the output port is not retracted.
- On base_tick for a RUN channel:
  - If rem == 1 the channel expires: pend is set; periodic mode reloads rem = period; one-shot mode goes to IDLE.
  - Otherwise rem decrements by 1.
  - Expiry therefore falls on the P-th base_tick after start, and every P base_ticks thereafter in periodic mode.
- A config command and a base_tick on the same channel in the same cycle: the command wins and the tick is ignored for that channel.
- Overrun: if an expiry occurs while pend is already 1, overrun[ch] is set and pend stays 1. Events are not counted beyond one.
- Output register (evt_valid, evt_ch):
  - Loads when (!evt_valid || evt_ready) and any pend bit is set.
  - The chosen channel is the first set pend bit searching from the pointer upward, with wrap.
  - Loading clears that pend bit and sets pointer = ch+1 (mod N_CH).
  - When no pend bit is set and a handshake occurs, evt_valid drops.
- Latency: expiry in base_tick cycle T sets pend at T+1; evt_valid is high at T+2 if the port is free.
- Back-to-back delivery: after a handshake in cycle H, the next pending event is valid in H+1, with no bubble.
- Stability: evt_ch and evt_valid are constant while evt_valid && !evt_ready.
- Set wins over clear: if a channel expires in the same cycle its pend bit is moved to the output register, pend ends at 1 and no overrun is flagged.
- busy[i] = (state == RUN).
- Arithmetic: the prescaler counter is $clog2(PRESC) bits wide; rem is PW bits wide; no saturation is needed because rem never decrements below 1.

Test Plan:
(All scenarios use F0=8, F1=2, so PRESC = 4; N_CH = 4; PW = 16.)
1. Release reset with no commands -> base_tick high in cycles 3, 7, 11, ...; evt_valid, busy and overrun stay 0.
2. Start ch0 one-shot P=3 at cycle 0, evt_ready=1 -> expiry on base_tick at cycle 11; evt_valid=1 with evt_ch=0 for exactly cycle 13; busy[0] falls after cycle 11; no further events.
3. Start ch1 and ch2 periodic P=2 in the same cycle, evt_ready=1 -> every 8 clocks, evt_ch=1 then evt_ch=2 on consecutive cycles; order alternates by round-robin pointer.
4. Start ch3 periodic P=1, evt_ready=0 -> evt_ch=3 is held stable; the next tick sets pend; the third tick sets overrun[3]. Raising evt_ready then delivers exactly 2 events. A new start of ch3 clears overrun[3].
5. Start all four channels periodic P=1, evt_ready=1 -> 4 events per base tick on consecutive cycles, order 0,1,2,3. A stop of ch2 issued while pend[2]=1 removes ch2 from the sequence.
6. Pull rst_n low while evt_valid=1 and channels are busy -> evt_valid, busy, overrun and base_tick go to 0 immediately; after release, base_tick next occurs at cycle 3.
